// File: rtl/md5_op_pipe.sv
// One MD5 operation as an elastic valid/ready pipeline of 1..6 register stages.
// The message and a user tag ride alongside each word so 64 stages can be chained.
module md5_op_pipe #(
    parameter int                    INDEX       = 0,
    parameter int                    S           = 7,
    parameter logic [31:0]           K           = 32'hd76aa478,
    parameter int                    MSG_BITS    = 152,
    parameter logic [511-MSG_BITS:0] MSG_PAD     = '0,
    parameter int                    PIPE_STAGES = 6,
    parameter int                    TAG_W       = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    input  logic [31:0]         c,
    input  logic [31:0]         d,
    input  logic [MSG_BITS-1:0] m_in,
    input  logic [TAG_W-1:0]    tag_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [31:0]         a_out,
    output logic [31:0]         b_out,
    output logic [31:0]         c_out,
    output logic [31:0]         d_out,
    output logic [MSG_BITS-1:0] m_out,
    output logic [TAG_W-1:0]    tag_out,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int PAD_W = 512 - MSG_BITS;
    localparam int G     = (INDEX < 16) ? INDEX :
                           (INDEX < 32) ? ((5 * INDEX + 1) % 16) :
                           (INDEX < 48) ? ((3 * INDEX + 5) % 16) :
                                          ((7 * INDEX) % 16);
    localparam int P0    = 32 * (15 - G);
    localparam int NST   = PIPE_STAGES;
    // Steps 0..FIRST all collapse into the first register stage.
    localparam int FIRST = 6 - PIPE_STAGES;

    generate
        if (INDEX < 0 || INDEX > 63) begin : g_bad_index
            $error("md5_op_pipe: INDEX must be 0..63");
        end
        if (S < 0 || S > 31) begin : g_bad_s
            $error("md5_op_pipe: S must be 0..31");
        end
        if (MSG_BITS < 8 || MSG_BITS > 440 || (MSG_BITS % 8) != 0) begin : g_bad_msg
            $error("md5_op_pipe: MSG_BITS must be a multiple of 8 in 8..440");
        end
        if (PIPE_STAGES < 1 || PIPE_STAGES > 6) begin : g_bad_stages
            $error("md5_op_pipe: PIPE_STAGES must be 1..6");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("md5_op_pipe: TAG_W must be at least 1");
        end
    endgenerate

    typedef struct packed {
        logic [31:0] wa;
        logic [31:0] wb;
        logic [31:0] wc;
        logic [31:0] wd;
        logic [31:0] mw;
    } work_t;

    function automatic logic [31:0] round_f(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] z);
        if (INDEX < 16)      return (x & y) | (~x & z);
        else if (INDEX < 32) return (z & x) | (~z & y);
        else if (INDEX < 48) return x ^ y ^ z;
        else                 return y ^ (x | ~z);
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x);
        if (S == 0) return x;
        return (x << S) | (x >> (32 - S));
    endfunction

    // Accumulator wa carries a -> t -> r -> b+r; the last step renames lanes.
    function automatic work_t apply_step(input int step, input work_t w);
        work_t r;
        r = w;
        case (step)
            0: r.wa = w.wa + round_f(w.wb, w.wc, w.wd);
            1: r.wa = w.wa + w.mw;
            2: r.wa = w.wa + K;
            3: r.wa = rotl(w.wa);
            4: r.wa = w.wb + w.wa;
            5: begin
                r.wa = w.wd;
                r.wb = w.wa;
                r.wc = w.wb;
                r.wd = w.wc;
            end
            default: r = w;
        endcase
        return r;
    endfunction

    // Only the four bytes of word G are pulled out, straight from either m_in or the pad.
    logic [31:0] m_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mbyte
            localparam int P = P0 + 8 * (3 - gi);
            if (P >= PAD_W) begin : g_from_msg
                assign m_word[8*gi +: 8] = m_in[P-PAD_W +: 8];
            end else begin : g_from_pad
                assign m_word[8*gi +: 8] = MSG_PAD[P +: 8];
            end
        end
    endgenerate

    work_t               in_work;
    work_t               work_reg  [NST];
    work_t               work_next [NST];
    logic [MSG_BITS-1:0] m_reg     [NST];
    logic [MSG_BITS-1:0] m_src     [NST];
    logic [TAG_W-1:0]    tag_reg   [NST];
    logic [TAG_W-1:0]    tag_src   [NST];
    logic [NST-1:0]      full_reg;
    logic [NST-1:0]      src_full;
    logic [NST-1:0]      can_take;

    assign in_work = '{wa: a, wb: b, wc: c, wd: d, mw: m_word};

    always_comb begin
        work_t w;
        w = in_work;
        for (int s = 0; s <= FIRST; s++) begin
            w = apply_step(s, w);
        end
        work_next[0] = w;
        m_src[0]     = m_in;
        tag_src[0]   = tag_in;
        src_full[0]  = in_valid;
        for (int i = 1; i < NST; i++) begin
            work_next[i] = apply_step(FIRST + i, work_reg[i-1]);
            m_src[i]     = m_reg[i-1];
            tag_src[i]   = tag_reg[i-1];
            src_full[i]  = full_reg[i-1];
        end
    end

    // Ready ripples back from out_ready so a full pipe can accept and deliver in one cycle.
    always_comb begin
        can_take[NST-1] = !full_reg[NST-1] || out_ready;
        for (int i = NST - 2; i >= 0; i--) begin
            can_take[i] = !full_reg[i] || can_take[i+1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full_reg <= '0;
            for (int i = 0; i < NST; i++) begin
                work_reg[i] <= '0;
                m_reg[i]    <= '0;
                tag_reg[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NST; i++) begin
                if (can_take[i]) begin
                    full_reg[i] <= src_full[i];
                    // Bubbles leave the data registers untouched.
                    if (src_full[i]) begin
                        work_reg[i] <= work_next[i];
                        m_reg[i]    <= m_src[i];
                        tag_reg[i]  <= tag_src[i];
                    end
                end
            end
        end
    end

    assign in_ready  = can_take[0];
    assign out_valid = full_reg[NST-1];
    assign a_out     = work_reg[NST-1].wa;
    assign b_out     = work_reg[NST-1].wb;
    assign c_out     = work_reg[NST-1].wc;
    assign d_out     = work_reg[NST-1].wd;
    assign m_out     = m_reg[NST-1];
    assign tag_out   = tag_reg[NST-1];

endmodule

// File: tb/tb_md5_op_pipe.sv
// Directed and stalled-stream checks of md5_op_pipe at depths 6, 3 and 1.
module tb_md5_op_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic [31:0]  a_in, b_in, c_in, d_in;
    logic [439:0] m_wide;
    logic [7:0]   tag_in;
    logic [2:0]   in_valid, out_ready, in_ready, out_valid;
    logic [31:0]  a_o [3];
    logic [31:0]  b_o [3];
    logic [31:0]  c_o [3];
    logic [31:0]  d_o [3];
    logic [7:0]   tag_o [3];
    logic [151:0] m_out0, m_out1;
    logic [439:0] m_out2;

    md5_op_pipe #(.INDEX(32), .S(4), .K(32'h1), .MSG_BITS(152), .PIPE_STAGES(6), .TAG_W(8)) u_dut6 (
        .clk(clk), .reset_n(reset_n), .a(a_in), .b(b_in), .c(c_in), .d(d_in),
        .m_in(m_wide[439:288]), .tag_in(tag_in), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a_out(a_o[0]), .b_out(b_o[0]), .c_out(c_o[0]), .d_out(d_o[0]), .m_out(m_out0),
        .tag_out(tag_o[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]));

    md5_op_pipe #(.INDEX(0), .S(0), .K(32'h0), .MSG_BITS(152), .PIPE_STAGES(3), .TAG_W(8)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .a(a_in), .b(b_in), .c(c_in), .d(d_in),
        .m_in(m_wide[439:288]), .tag_in(tag_in), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a_out(a_o[1]), .b_out(b_o[1]), .c_out(c_o[1]), .d_out(d_o[1]), .m_out(m_out1),
        .tag_out(tag_o[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]));

    md5_op_pipe #(.INDEX(60), .S(10), .K(32'h100), .MSG_BITS(440), .PIPE_STAGES(1), .TAG_W(8)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .a(a_in), .b(b_in), .c(c_in), .d(d_in),
        .m_in(m_wide), .tag_in(tag_in), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a_out(a_o[2]), .b_out(b_o[2]), .c_out(c_o[2]), .d_out(d_o[2]), .m_out(m_out2),
        .tag_out(tag_o[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]));

    typedef struct packed {
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  c;
        logic [31:0]  d;
        logic [7:0]   tag;
        logic [439:0] m;
    } word_t;

    word_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string tag, input logic [439:0] got, input logic [439:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int stages(input int id);
        return (id == 0) ? 6 : (id == 1) ? 3 : 1;
    endfunction

    function automatic logic [439:0] mout_of(input int id);
        if (id == 0) return {m_out0, 288'b0};
        if (id == 1) return {m_out1, 288'b0};
        return m_out2;
    endfunction

    function automatic logic [439:0] mmask(input int id);
        logic [439:0] ones;
        ones = '1;
        return (id == 2) ? ones : ~(ones >> 152);
    endfunction

    // Reference MD5 step written from the textbook definition.
    task automatic md5_ref(input int id, input word_t w, output logic [31:0] ea, output logic [31:0] eb,
                           output logic [31:0] ec, output logic [31:0] ed);
        int           idx, s, g;
        logic [31:0]  k, f, mword, be, t, r;
        logic [511:0] full;
        logic [511:0] ones;
        ones = '1;
        case (id)
            0:       begin idx = 32; s = 4;  k = 32'h1;   full = {w.m, 72'b0} & ~(ones >> 152); end
            1:       begin idx = 0;  s = 0;  k = 32'h0;   full = {w.m, 72'b0} & ~(ones >> 152); end
            default: begin idx = 60; s = 10; k = 32'h100; full = {w.m, 72'b0}; end
        endcase
        if (idx < 16)      begin f = (w.b & w.c) | (~w.b & w.d); g = idx; end
        else if (idx < 32) begin f = (w.d & w.b) | (~w.d & w.c); g = (5 * idx + 1) % 16; end
        else if (idx < 48) begin f = w.b ^ w.c ^ w.d;           g = (3 * idx + 5) % 16; end
        else               begin f = w.c ^ (w.b | ~w.d);        g = (7 * idx) % 16; end
        be    = full[32*(15-g) +: 32];
        mword = {be[7:0], be[15:8], be[23:16], be[31:24]};
        t     = w.a + f + mword + k;
        r     = (s == 0) ? t : ((t << s) | (t >> (32 - s)));
        ea = w.d;
        eb = w.b + r;
        ec = w.b;
        ed = w.c;
    endtask

    function automatic word_t rand_word(input int seq);
        word_t w;
        w.a   = $urandom;
        w.b   = $urandom;
        w.c   = $urandom;
        w.d   = $urandom;
        w.tag = 8'(seq);
        w.m   = '0;
        for (int i = 0; i < 14; i++) w.m = {w.m[407:0], 32'($urandom)};
        return w;
    endfunction

    task automatic apply_word(input word_t w);
        a_in = w.a; b_in = w.b; c_in = w.c; d_in = w.d; tag_in = w.tag; m_wide = w.m;
    endtask

    task automatic check_word(input int id, input word_t w, input string name);
        logic [31:0] ea, eb, ec, ed;
        md5_ref(id, w, ea, eb, ec, ed);
        check({name, "_a"}, 440'(a_o[id]), 440'(ea));
        check({name, "_b"}, 440'(b_o[id]), 440'(eb));
        check({name, "_c"}, 440'(c_o[id]), 440'(ec));
        check({name, "_d"}, 440'(d_o[id]), 440'(ed));
        check({name, "_tag"}, 440'(tag_o[id]), 440'(w.tag));
        check({name, "_m"}, mout_of(id), w.m & mmask(id));
        $display("dut%0d %s tag=%0d a=%h b=%h c=%h d=%h", id, name, tag_o[id], a_o[id], b_o[id], c_o[id], d_o[id]);
    endtask

    // Single hand-computed word: checks latency and exact output values.
    task automatic directed(input int id, input word_t w, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [31:0] ec, input logic [31:0] ed, input string name);
        int lat;
        @(negedge clk);
        apply_word(w);
        in_valid = '0; in_valid[id] = 1'b1;
        out_ready = '0; out_ready[id] = 1'b1;
        #1;
        check({name, "_in_ready"}, 440'(in_ready[id]), 440'(1));
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = '0;
            #1;
            lat++;
        end while (!out_valid[id] && lat < 20);
        check({name, "_latency"}, 440'(lat), 440'(stages(id)));
        check({name, "_a"}, 440'(a_o[id]), 440'(ea));
        check({name, "_b"}, 440'(b_o[id]), 440'(eb));
        check({name, "_c"}, 440'(c_o[id]), 440'(ec));
        check({name, "_d"}, 440'(d_o[id]), 440'(ed));
        check({name, "_tag"}, 440'(tag_o[id]), 440'(w.tag));
        $display("dut%0d %s lat=%0d a=%h b=%h c=%h d=%h", id, name, lat, a_o[id], b_o[id], c_o[id], d_o[id]);
        @(negedge clk);
        out_ready = '0;
    endtask

    // Producer/consumer loop with percent-probability valid and ready; hold forces out_ready low first.
    task automatic run_stream(input int id, input int nwords, input int p_in, input int p_out,
                              input int hold, input bit timing, input string name);
        word_t cur, w;
        bit    pending, acc, dlv;
        int    sent, got, it, first_acc, first_dlv, last_dlv;
        pending = 0; sent = 0; got = 0; it = 0;
        first_acc = -1; first_dlv = -1; last_dlv = -1;
        cur = '0;
        exp_q.delete();
        while (got < nwords && it < 4000) begin
            @(negedge clk);
            if (!pending && sent < nwords && $urandom_range(99) < p_in) begin
                cur = rand_word(sent);
                apply_word(cur);
                pending = 1;
            end
            in_valid = '0; in_valid[id] = pending;
            out_ready = '0; out_ready[id] = (it >= hold) && ($urandom_range(99) < p_out);
            #1;
            acc = pending && in_ready[id];
            dlv = out_valid[id] && out_ready[id];
            if (dlv) begin
                if (exp_q.size() == 0) begin
                    check({name, "_unexpected_word"}, 440'(out_valid[id]), 440'(0));
                end else begin
                    w = exp_q.pop_front();
                    check_word(id, w, name);
                end
                got++;
                if (first_dlv < 0) first_dlv = it;
                last_dlv = it;
            end
            if (acc) begin
                exp_q.push_back(cur);
                pending = 0;
                sent++;
                if (first_acc < 0) first_acc = it;
            end
            if (hold > 0 && it == hold - 1) begin
                check({name, "_held_words"}, 440'(sent), 440'(stages(id)));
                check({name, "_in_ready_full"}, 440'(in_ready[id]), 440'(0));
            end
            it++;
        end
        @(negedge clk);
        in_valid = '0;
        out_ready = '0;
        check({name, "_delivered"}, 440'(got), 440'(nwords));
        check({name, "_leftover"}, 440'(exp_q.size()), 440'(0));
        if (timing) begin
            check({name, "_latency"}, 440'(first_dlv - first_acc), 440'(stages(id)));
            check({name, "_span"}, 440'(last_dlv - first_dlv), 440'(nwords - 1));
        end
    endtask

    initial begin
        word_t w;
        int    seen;
        reset_n = 1'b0;
        in_valid = '0; out_ready = '0;
        a_in = '0; b_in = '0; c_in = '0; d_in = '0; tag_in = '0; m_wide = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        for (int id = 0; id < 3; id++) begin
            check("rst_out_valid", 440'(out_valid[id]), 440'(0));
            check("rst_in_ready", 440'(in_ready[id]), 440'(1));
            check("rst_a", 440'(a_o[id]), 440'(0));
            check("rst_b", 440'(b_o[id]), 440'(0));
            check("rst_tag", 440'(tag_o[id]), 440'(0));
            check("rst_m", mout_of(id), 440'(0));
        end

        // a=0x10,b=1: F=1, M[5]=0, t=0x12, rotl4=0x120, b_out=0x121.
        w = '0; w.a = 32'h10; w.b = 32'h1; w.tag = 8'h5a;
        directed(0, w, 32'h0, 32'h121, 32'h1, 32'h0, "byteswap6");

        // "abcd" as M[0] little-endian with zero state and S=0.
        w = '0; w.m[439:408] = 32'h61626364; w.tag = 8'h11;
        directed(1, w, 32'h0, 32'h64636261, 32'h0, 32'h0, "rot0_3");

        // F=0xF0^0xF=0xFF, M[4]=1, t=0x200, rotl10=0x80000, b_out=0x8000F.
        w = '0; w.b = 32'hf; w.c = 32'hf0; w.d = 32'hffffffff; w.m[311:280] = 32'h01000000; w.tag = 8'h22;
        directed(2, w, 32'hffffffff, 32'h8000f, 32'hf, 32'hf0, "index60_1");

        run_stream(0, 20, 100, 100, 0, 1'b1, "thru6");
        run_stream(1, 20, 100, 100, 0, 1'b1, "thru3");
        run_stream(2, 20, 100, 100, 0, 1'b1, "thru1");

        run_stream(0, 8, 100, 100, 10, 1'b0, "bp6");

        run_stream(0, 120, 70, 50, 0, 1'b0, "rnd6");
        run_stream(1, 100, 50, 70, 0, 1'b0, "rnd3");
        run_stream(2, 120, 60, 60, 0, 1'b0, "rnd1");

        // Four words in flight, then a one-cycle reset.
        out_ready = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            apply_word(rand_word(200 + i));
            in_valid = '0; in_valid[0] = 1'b1;
        end
        @(negedge clk);
        in_valid = '0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("midrst_out_valid", 440'(out_valid[0]), 440'(0));
        check("midrst_in_ready", 440'(in_ready[0]), 440'(1));
        check("midrst_a", 440'(a_o[0]), 440'(0));
        check("midrst_b", 440'(b_o[0]), 440'(0));
        check("midrst_c", 440'(c_o[0]), 440'(0));
        check("midrst_d", 440'(d_o[0]), 440'(0));
        check("midrst_tag", 440'(tag_o[0]), 440'(0));
        check("midrst_m", mout_of(0), 440'(0));
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            out_ready = '0; out_ready[0] = 1'b1;
            #1;
            if (out_valid[0]) seen++;
        end
        check("midrst_ghost_words", 440'(seen), 440'(0));
        out_ready = '0;

        w = '0; w.a = 32'h10; w.b = 32'h1; w.tag = 8'h77;
        directed(0, w, 32'h0, 32'h121, 32'h1, 32'h0, "after_rst6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
